// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the multicycle ALU.
// Used by the top-level decoder/FSM and the testbench-independent RTL.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MULT = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIN
    } state_t;

    function automatic logic is_single(input logic [3:0] op);
        return op inside {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL,
                          ALU_AND, ALU_OR, ALU_XOR, ALU_NOR};
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier / restoring divider, one bit per step.
// Ports: clk, resetn, load (latch op_a/op_b, load counter), step (one
// iteration), mode_div (1=divide), acc_hi/acc_lo (product or rem/quot),
// last (counter==1, final iteration in progress).
module alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic             mode_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo,
    output logic             last
);

    localparam int CW = $clog2(ITER + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi_r, lo_r, b_r;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic [WIDTH:0]   sum, shifted, diff;

    // hi_r holds the partial product (mult) or partial remainder (div);
    // lo_r holds the multiplier being consumed or the dividend being
    // replaced bit by bit with the quotient.
    always_comb begin
        sum     = {1'b0, hi_r} + {1'b0, b_r};
        shifted = {hi_r, lo_r[WIDTH-1]};
        diff    = shifted - {1'b0, b_r};
        nxt_hi  = hi_r;
        nxt_lo  = lo_r;
        if (mode_div) begin
            // Remainder stays below the divisor, so bit WIDTH of the
            // difference is a clean borrow flag.
            if (!diff[WIDTH]) begin
                nxt_hi = diff[WIDTH-1:0];
                nxt_lo = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[WIDTH-1:0];
                nxt_lo = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else if (lo_r[0]) begin
            {nxt_hi, nxt_lo} = {sum, lo_r[WIDTH-1:1]};
        end else begin
            {nxt_hi, nxt_lo} = {1'b0, hi_r, lo_r[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            hi_r <= '0;
            lo_r <= '0;
            b_r  <= '0;
        end else if (load) begin
            cnt  <= CW'(ITER);
            hi_r <= '0;
            lo_r <= op_a;
            b_r  <= op_b;
        end else if (step) begin
            cnt  <= cnt - CW'(1);
            hi_r <= nxt_hi;
            lo_r <= nxt_lo;
        end
    end

    assign acc_hi = hi_r;
    assign acc_lo = lo_r;
    assign last   = (cnt == CW'(1));

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle arithmetic/logic/shift ops plus iterative
// unsigned mult/div. Ports: clk, resetn, start, ALU_control, src_a, src_b,
// shamt in; registered result/hi/lo/zero, busy and one-cycle done out.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    state_t state, nxt_state;

    logic             accept;
    logic             load, step, last;
    logic             wr_res, wr_iter, wr_div0, done_d;
    logic [WIDTH-1:0] alu_out, acc_hi, acc_lo;

    assign busy   = (state == MUL) || (state == DIV);
    assign accept = start && !busy;

    always_comb begin
        alu_out = '0;
        case (ALU_control)
            ALU_ADD: alu_out = src_a + src_b;
            ALU_SUB: alu_out = src_a - src_b;
            ALU_SLL: alu_out = src_b << shamt;
            ALU_SRL: alu_out = src_b >> shamt;
            ALU_AND: alu_out = src_a & src_b;
            ALU_OR:  alu_out = src_a | src_b;
            ALU_XOR: alu_out = src_a ^ src_b;
            ALU_NOR: alu_out = ~(src_a | src_b);
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nxt_state;
    end

    // FIN and IDLE both accept a new request; FIN additionally commits
    // the iterative result, so back-to-back issue costs no bubble.
    always_comb begin
        nxt_state = state;
        load      = 1'b0;
        step      = 1'b0;
        wr_res    = 1'b0;
        wr_iter   = 1'b0;
        wr_div0   = 1'b0;
        done_d    = 1'b0;
        unique case (state)
            MUL, DIV: begin
                step = 1'b1;
                if (last) nxt_state = FIN;
            end
            IDLE, FIN: begin
                if (state == FIN) begin
                    wr_iter   = 1'b1;
                    done_d    = 1'b1;
                    nxt_state = IDLE;
                end
                if (accept) begin
                    if (is_single(ALU_control)) begin
                        wr_res = 1'b1;
                        done_d = 1'b1;
                    end else if (ALU_control == ALU_MULT) begin
                        load      = 1'b1;
                        nxt_state = MUL;
                    end else if (ALU_control == ALU_DIV) begin
                        if (src_b == '0) begin
                            wr_div0 = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            load      = 1'b1;
                            nxt_state = DIV;
                        end
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH(WIDTH),
        .ITER (ITER)
    ) u_iter (
        .clk     (clk),
        .resetn  (resetn),
        .load    (load),
        .step    (step),
        .mode_div(state == DIV),
        .op_a    (src_a),
        .op_b    (src_b),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .last    (last)
    );

    // A div-by-zero accepted in FIN overrides the mult/div commit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result <= '0;
            hi     <= '0;
            lo     <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
        end else begin
            done <= done_d;
            if (wr_res) begin
                result <= alu_out;
                zero   <= (alu_out == '0);
            end
            if (wr_div0) begin
                hi <= src_a;
                lo <= '1;
            end else if (wr_iter) begin
                hi <= acc_hi;
                lo <= acc_lo;
            end
        end
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width.
REQ-002 Parameter ITER, default WIDTH: mult/div iteration count, one bit per cycle.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request strobe; sampled only when busy=0.
REQ-006 ALU_control  input  4  operation code from the ALU decoder.
REQ-007 src_a  input  WIDTH  operand A (rs).
REQ-008 src_b  input  WIDTH  operand B (rt or immediate).
REQ-009 shamt  input  5  shift amount for sll/srl.
REQ-010 result  output  WIDTH  registered result of the last single-cycle op.
REQ-011 hi  output  WIDTH  registered HI (mult upper half / div remainder).
REQ-012 lo  output  WIDTH  registered LO (mult lower half / div quotient).
REQ-013 zero  output  1  registered, 1 when result==0.
REQ-014 busy  output  1  high while a mult/div is iterating.
REQ-015 done  output  1  one-cycle pulse; result/hi/lo valid in the same cycle.

Function
REQ-016 Codes: 0000 add, 0001 sub, 0010 mult, 0011 div, 0100 sll, 0101 srl, 1000 and, 1001 or, 1010 xor, 1011 nor; all other codes are illegal.
REQ-017 States: IDLE, MUL, DIV, FIN; reset state is IDLE.
REQ-018 IDLE with start=1 and a single-cycle code: result is computed and registered at that edge, and done=1 in the next cycle; the state stays IDLE.
REQ-019 add/sub are modulo 2^WIDTH with no overflow trap; sll/srl shift src_b by shamt, zero-filled.
REQ-020 IDLE with start=1 and mult/div: operands are latched, iteration counter is loaded with ITER, and the state moves to MUL or DIV; busy=1 from the next cycle.
REQ-021 MUL: unsigned shift-add, one bit per cycle; counter decrements each cycle; the state moves to FIN when the counter reaches 1.
REQ-022 DIV: unsigned restoring division, one quotient bit per cycle; same counter rule as MUL.
REQ-023 FIN: hi/lo are written, done=1, busy=0, and the state returns to IDLE; total latency is ITER+1 cycles from the accepting edge to done.
REQ-024 div with src_b==0: no iteration; lo = all ones and hi = src_a; done is asserted in the next cycle, as for a single-cycle op.
REQ-025 Illegal code with start=1: done pulses in the next cycle and result/hi/lo are left unchanged.
REQ-026 start while busy=1: ignored; no queuing, and in-flight operands are not disturbed.
REQ-027 start asserted in the FIN cycle: accepted, so back-to-back operation is allowed.
REQ-028 result and zero are not modified by mult/div; hi and lo are not modified by single-cycle ops.
REQ-029 done is never high for two consecutive cycles from a single request.

Reset
REQ-030 While resetn=0: state=IDLE, result=0, hi=0, lo=0, zero=1, busy=0, done=0, counter=0.
REQ-031 Reset asserted mid mult/div aborts the operation with no done pulse; the state is IDLE after release.
REQ-032 The first edge after resetn rises is a normal edge: start is accepted on it.

Structure
REQ-033 Shared package alu_pkg holds the 4-bit ALU_control code constants and the state enum; the ALU decoder uses the same constants.
REQ-034 One sub-module, alu_muldiv_iter, holds the counter, the partial-product/remainder registers and the MUL/DIV datapath; the top level holds the FSM, the single-cycle datapath and the output registers.

Verification
REQ-035 add 0xFFFFFFFF+0x00000001 -> result=0, zero=1, done one cycle after start.
REQ-036 mult 0x0001_0000 x 0x0001_0000 -> hi=0x00000001, lo=0, done 33 cycles after the accepting edge, busy high for 32 cycles.
REQ-037 div 100/7 -> lo=14, hi=2; a second start issued mid-operation is ignored, with exactly one done.
REQ-038 div 5/0 -> lo=0xFFFFFFFF, hi=5, done one cycle after start.
REQ-039 srl src_b=0x80000000 with shamt=31 -> result=1; nor of 0 and 0 -> 0xFFFFFFFF.
REQ-040 resetn pulled low at iteration 10 of a mult -> busy=0, hi=lo=0, no done; a new add is accepted right after release.
